load_store_unit: RTL and testbench

Sub-word load/store front end that sits directly upstream of the byte-addressed data memory and is its only driver. It accepts one core load or store request at a time and issues only word-aligned, full-word accesses to the memory. Byte and halfword stores become read-modify-write sequences, and load data is extracted and sign- or zero-extended here. It also flags misaligned, out-of-range and illegal requests without touching memory.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
// The slave modport is the unit's view; master is the core plus memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr_en;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
             mem_addr, mem_wdata, mem_wr_en
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
             mem_addr, mem_wdata, mem_wr_en
   );
endinterface

// File: rtl/load_store_unit.sv
// Sub-word load/store front end for a byte-addressed, word-wide data memory.
// Issues only aligned full-word accesses; byte/half stores become a
// read-modify-write, load data is extracted and extended here.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 8192
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] rdata_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        wr_q;

   logic        bad_f3;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic [31:0] shifted;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;
   logic [31:0] merge_word;

   // Classify the incoming request: illegal width code, misalignment, range.
   always_comb begin
      if (bus.req_we)
         bad_f3 = bus.req_funct3[2] || (bus.req_funct3 == 3'b011);
      else
         bad_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111);
      misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      // Aligned word address + 3 is just the address with low bits set, so it cannot wrap.
      out_of_range = {bus.req_addr[31:2], 2'b11} >= MEM_BYTES;
      req_err      = bad_f3 || misaligned || out_of_range;
   end

   // Lane extraction/extension for loads and lane merge for sub-word stores.
   always_comb begin
      shifted   = bus.mem_rdata >> {lane_q, 3'b000};
      sel_byte  = shifted[7:0];
      sel_half  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (f3_q)
         3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_data = {24'd0, sel_byte};
         3'b101:  load_data = {16'd0, sel_half};
         default: load_data = bus.mem_rdata;
      endcase
      merge_word = bus.mem_rdata;
      if (f3_q[1:0] == 2'b00)
         merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merge_word[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   // Request sequencer with registered response and memory-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= '0;
         lane_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         wr_q         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               if (bus.req_valid) begin
                  we_q       <= bus.req_we;
                  f3_q       <= bus.req_funct3;
                  lane_q     <= bus.req_addr[1:0];
                  wdata_q    <= bus.req_wdata[15:0];
                  mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                  if (req_err) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     state        <= RESP;
                  end else begin
                     // A full-word store writes during ACCESS, so arm it now.
                     if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) begin
                        wr_q        <= 1'b1;
                        mem_wdata_q <= bus.req_wdata;
                     end
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  rdata_q      <= load_data;
                  resp_valid_q <= 1'b1;
                  wr_q         <= 1'b0;
                  state        <= RESP;
               end else if (f3_q[1:0] == 2'b10) begin
                  resp_valid_q <= 1'b1;
                  wr_q         <= 1'b0;
                  state        <= RESP;
               end else begin
                  mem_wdata_q <= merge_word;
                  wr_q        <= 1'b1;
                  state       <= WRITE;
               end
            end
            WRITE: begin
               wr_q         <= 1'b0;
               resp_valid_q <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE) && !rst;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wr_en  = wr_q && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory beside the DUT, a byte-level
// reference model, directed scenarios and randomized requests.
module tb_load_store_unit;
   localparam int unsigned MEM_BYTES = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_req = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]  mem     [MEM_BYTES];
   logic [7:0]  ref_mem [MEM_BYTES];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] last_rdata = '0;

   // Cycle counter used to measure accept spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Data memory: writes on the falling edge, preload copies the reference image.
   always @(negedge clk) begin
      if (init_req) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];
      end else if (bus.mem_wr_en && (bus.mem_addr <= MEM_BYTES - 4)) begin
         for (int i = 0; i < 4; i++) mem[int'(bus.mem_addr) + i] <= bus.mem_wdata[8*i +: 8];
      end
   end

   // Combinational read port.
   always_comb begin
      bus.mem_rdata = '0;
      if (bus.mem_addr <= MEM_BYTES - 4)
         for (int i = 0; i < 4; i++) bus.mem_rdata[8*i +: 8] = mem[int'(bus.mem_addr) + i];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
      bit bad;
      int unsigned sz;
      longint unsigned last;
      if (we) bad = (f3 > 3'd2);
      else    bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      sz   = 1 << f3[1:0];
      last = 64'(a - (a % 4)) + 3;
      return bad || ((a % sz) != 0) || (last >= MEM_BYTES);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      int unsigned sz;
      logic [63:0] v;
      sz = 1 << f3[1:0];
      v  = '0;
      for (int unsigned i = 0; i < sz; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
      return v[31:0];
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int unsigned sz;
      sz = 1 << f3[1:0];
      for (int unsigned i = 0; i < sz; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "/req_ready"},  32'(bus.req_ready),  32'd0);
      check_eq({tag, "/resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check_eq({tag, "/resp_err"},   32'(bus.resp_err),   32'd0);
      check_eq({tag, "/resp_rdata"}, bus.resp_rdata,      32'd0);
      check_eq({tag, "/mem_wr_en"},  32'(bus.mem_wr_en),  32'd0);
      check_eq({tag, "/mem_addr"},   bus.mem_addr,        32'd0);
      check_eq({tag, "/mem_wdata"},  bus.mem_wdata,       32'd0);
   endtask

   // One request, entered and left #1 after a rising edge.
   task automatic run_req(input string tag, input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_rdata);
      bit          exp_err;
      int          exp_lat, exp_wr, n_resp, resp_cyc, n_wr, wr_cyc, w;
      logic [31:0] exp_rdata, got_err;
      exp_err   = model_err(we, f3, a);
      exp_lat   = exp_err ? 1 : ((!we || f3[1:0] == 2'b10) ? 2 : 3);
      exp_wr    = (we && !exp_err) ? 1 : 0;
      exp_rdata = (!we && !exp_err) ? model_load(f3, a) : last_rdata;
      got_rdata = bus.resp_rdata;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      if (!bus.req_ready) begin
         check_eq({tag, "/ready_timeout"}, 32'd0, 32'd1);
         return;
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n_resp = 0; resp_cyc = 0; n_wr = 0; wr_cyc = 0; got_err = '0;
      for (int k = 1; k <= 5; k++) begin
         if (bus.resp_valid) begin
            n_resp++;
            resp_cyc = k;
            got_err  = 32'(bus.resp_err);
         end
         if (bus.mem_wr_en) begin
            n_wr++;
            wr_cyc = k;
         end
         @(posedge clk); #1;
      end
      got_rdata = bus.resp_rdata;
      check_eq({tag, "/resp_count"}, n_resp, 1);
      check_eq({tag, "/resp_cycle"}, resp_cyc, exp_lat);
      check_eq({tag, "/resp_err"},   got_err, 32'(exp_err));
      check_eq({tag, "/resp_rdata"}, got_rdata, exp_rdata);
      check_eq({tag, "/wr_count"},   n_wr, exp_wr);
      if (exp_wr > 0) check_eq({tag, "/wr_cycle"}, wr_cyc, exp_lat - 1);
      if (we && !exp_err) model_store(f3, a, wd);
      last_rdata = exp_rdata;
   endtask

   logic [31:0] rd;
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   int          acc_cyc [3];

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
      init_req = 1'b1;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst      = 1'b0;
      init_req = 1'b0;
      @(posedge clk); #1;
      check_eq("ready_after_reset", 32'(bus.req_ready), 32'd1);

      // Full-word store then sub-word loads.
      run_req("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
      run_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0, rd);
      check_eq("lw10_const", rd, 32'hDEADBEEF);
      run_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, rd);
      check_eq("lb13_const", rd, 32'hFFFFFFDE);
      run_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, rd);
      check_eq("lbu13_const", rd, 32'h000000DE);
      run_req("lh10",  1'b0, 3'b001, 32'h10, 32'h0, rd);
      check_eq("lh10_const", rd, 32'hFFFFBEEF);

      // Read-modify-write merges.
      run_req("sb11",  1'b1, 3'b000, 32'h11, 32'h12, rd);
      run_req("sh12",  1'b1, 3'b001, 32'h12, 32'hA5A5, rd);
      run_req("lw10m", 1'b0, 3'b010, 32'h10, 32'h0, rd);
      check_eq("merge_const", rd, 32'hA5A512EF);

      // Rejected requests and range edges.
      run_req("err_lh11",  1'b0, 3'b001, 32'h11, 32'h0, rd);
      run_req("err_sw12",  1'b1, 3'b010, 32'h12, 32'h55, rd);
      run_req("err_range", 1'b0, 3'b010, MEM_BYTES, 32'h0, rd);
      run_req("err_f3_3",  1'b0, 3'b011, 32'h10, 32'h0, rd);
      run_req("err_wrap",  1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, rd);
      run_req("top_word",  1'b0, 3'b010, MEM_BYTES - 4, 32'h0, rd);
      check_eq("err_keeps_rdata", rd, model_load(3'b010, MEM_BYTES - 4));

      // Back-to-back loads with req_valid held high.
      exp_q.push_back(model_load(3'b010, 32'h10));
      exp_q.push_back(model_load(3'b010, 32'h14));
      exp_q.push_back(model_load(3'b100, 32'h11));
      fork
         begin
            logic [31:0] addrs [3];
            logic [2:0]  f3s [3];
            addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h11;
            f3s[0] = 3'b010;   f3s[1] = 3'b010;   f3s[2] = 3'b100;
            for (int i = 0; i < 3; i++) begin
               int w;
               bus.req_valid  = 1'b1;
               bus.req_we     = 1'b0;
               bus.req_funct3 = f3s[i];
               bus.req_addr   = addrs[i];
               w = 0;
               while (!bus.req_ready && w < 10) begin
                  @(posedge clk); #1;
                  w++;
               end
               @(posedge clk); #1;
               acc_cyc[i] = cyc;
            end
            bus.req_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 20; k++) begin
               @(posedge clk); #1;
               if (bus.resp_valid) got_q.push_back(bus.resp_rdata);
            end
         end
      join
      check_eq("b2b/resp_count", got_q.size(), 3);
      for (int i = 0; i < 3; i++)
         check_eq("b2b/rdata", (i < got_q.size()) ? got_q[i] : 32'hXXXXXXXX, exp_q[i]);
      check_eq("b2b/spacing01", acc_cyc[1] - acc_cyc[0], 3);
      check_eq("b2b/spacing12", acc_cyc[2] - acc_cyc[1], 3);
      last_rdata = exp_q[2];

      // Reset during the write cycle of a byte store.
      run_req("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, rd);
      begin
         int pulses;
         pulses = 0;
         bus.req_valid  = 1'b1;
         bus.req_we     = 1'b1;
         bus.req_funct3 = 3'b000;
         bus.req_addr   = 32'h20;
         bus.req_wdata  = 32'h77;
         @(posedge clk); #1;
         bus.req_valid = 1'b0;
         if (bus.resp_valid) pulses++;
         @(posedge clk); #1;
         rst = 1'b1;
         if (bus.resp_valid) pulses++;
         @(negedge clk);
         check_eq("rst_rmw/wr_gated", 32'(bus.mem_wr_en), 32'd0);
         check_eq("rst_rmw/ready_low", 32'(bus.req_ready), 32'd0);
         @(posedge clk); #1;
         check_reset_outputs("rst_rmw");
         @(posedge clk); #1;
         check_reset_outputs("rst_rmw2");
         rst = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (bus.resp_valid) pulses++;
            @(posedge clk); #1;
         end
         check_eq("rst_rmw/no_resp", pulses, 0);
      end
      last_rdata = '0;
      run_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, rd);
      check_eq("rst_rmw/lw20_const", rd, 32'h11223344);

      // Randomized requests.
      for (int n = 0; n < 250; n++) begin
         bit          we;
         logic [2:0]  f3;
         logic [31:0] a;
         int unsigned sel;
         we  = 1'($urandom);
         sel = $urandom_range(0, 15);
         f3  = (sel < 12) ? 3'($urandom_range(0, 2)) | (we ? 3'b000 : {1'($urandom), 2'b00})
                          : 3'($urandom);
         sel = $urandom_range(0, 15);
         if (sel < 13)       a = $urandom_range(0, 127);
         else if (sel < 15)  a = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 4);
         else                a = $urandom;
         run_req("rnd", we, f3, a, $urandom, rd);
      end

      // Final memory image over the exercised window.
      for (int i = 0; i < 128; i++) check_eq("mem_image", 32'(mem[i]), 32'(ref_mem[i]));
      for (int i = MEM_BYTES - 8; i < MEM_BYTES; i++)
         check_eq("mem_image_top", 32'(mem[i]), 32'(ref_mem[i]));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
